// File: rtl/pd_alu_pkg.sv
// Shared types for the PD0 ALU datapath and its result queue.
//   alu_sel_t   : ALU select code carried with every result
//   alu_entry_t : one queued result {sel, res}
//   occ_state_t : occupancy state of the result queue
package pd_alu_pkg;

    localparam int DWIDTH = 32;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_OR  = 2'b11
    } alu_sel_t;

    typedef struct packed {
        alu_sel_t            sel;
        logic [DWIDTH-1:0]   res;
    } alu_entry_t;

    typedef enum logic [1:0] {
        OCC_EMPTY   = 2'b00,
        OCC_PARTIAL = 2'b01,
        OCC_FULL    = 2'b10
    } occ_state_t;

endpackage

// File: rtl/alu_result_queue_if.sv
// Handshake bundle between the ALU, the result queue and its consumer.
//   in_*  : ALU result push side (valid/ready)
//   out_* : head-of-queue pop side (valid/ready) plus head zero flag
//   slave  modport : the queue
//   master modport : the producer/consumer environment
interface alu_result_queue_if
    import pd_alu_pkg::*;
#(
    parameter int DWIDTH = pd_alu_pkg::DWIDTH
) ();

    logic              in_valid;
    logic              in_ready;
    alu_sel_t          in_sel;
    logic [DWIDTH-1:0] in_res;

    logic              out_valid;
    logic              out_ready;
    alu_sel_t          out_sel;
    logic [DWIDTH-1:0] out_res;
    logic              out_zero;

    modport slave (
        input  in_valid, in_sel, in_res, out_ready,
        output in_ready, out_valid, out_sel, out_res, out_zero
    );

    modport master (
        output in_valid, in_sel, in_res, out_ready,
        input  in_ready, out_valid, out_sel, out_res, out_zero
    );

endinterface

// File: rtl/sync_fifo_mem.sv
// Entry storage for the result queue: DEPTH x alu_entry_t.
//   clock : write clock
//   we, waddr, wdata : single synchronous write port
//   raddr, rdata     : asynchronous read port (first-word-fall-through head)
// Contents are not reset; the queue masks the head while empty.
module sync_fifo_mem
    import pd_alu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clock,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  alu_entry_t    wdata,
    input  logic [AW-1:0] raddr,
    output alu_entry_t    rdata
);

    alu_entry_t mem_reg [DEPTH];

    always_ff @(posedge clock) begin
        if (we) begin
            mem_reg[waddr] <= wdata;
        end
    end

    assign rdata = mem_reg[raddr];

endmodule

// File: rtl/alu_result_queue.sv
// FWFT queue of ALU results between the ALU and writeback/trace.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   q_if         : push (in_*) and pop (out_*) handshakes
//   flush        : synchronous discard of all queued entries
//   count        : number of occupied entries
//   retired      : entries popped since reset (wraps)
module alu_result_queue
    import pd_alu_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DWIDTH = pd_alu_pkg::DWIDTH,
    parameter int CNT_W  = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    alu_result_queue_if.slave      q_if,
    input  logic                   flush,
    output logic [$clog2(DEPTH):0] count,
    output logic [CNT_W-1:0]       retired
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic [CW-1:0]    count_next;
    logic [CNT_W-1:0] retired_reg;
    occ_state_t       state_reg;
    logic             in_ready_reg;
    logic             out_valid_reg;

    logic             push;
    logic             pop;
    alu_entry_t       wr_entry;
    alu_entry_t       head_entry;

    assign push = q_if.in_valid && in_ready_reg;
    assign pop  = out_valid_reg && q_if.out_ready;

    assign wr_entry.sel = q_if.in_sel;
    assign wr_entry.res = q_if.in_res;

    sync_fifo_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clock (clock),
        .we    (push && !flush && !reset),
        .waddr (wr_ptr_reg),
        .wdata (wr_entry),
        .raddr (rd_ptr_reg),
        .rdata (head_entry)
    );

    assign count_next = count_reg + CW'(push) - CW'(pop);

    // Pointers, occupancy and the retired counter. A flush discards the
    // same-cycle push and pop, so retired only moves on an unflushed pop.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            count_reg   <= '0;
            retired_reg <= '0;
        end else if (flush) begin
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            count_reg   <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg  <= rd_ptr_reg + AW'(1);
                retired_reg <= retired_reg + CNT_W'(1);
            end
            count_reg <= count_next;
        end
    end

    // Occupancy FSM; in_ready and out_valid are registered outputs of it
    // so the handshakes depend only on state, never on same-cycle inputs.
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            state_reg     <= OCC_EMPTY;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                OCC_EMPTY: begin
                    if (push) begin
                        state_reg     <= OCC_PARTIAL;
                        out_valid_reg <= 1'b1;
                    end
                end
                OCC_PARTIAL: begin
                    if (push && !pop && (count_reg == CW'(DEPTH - 1))) begin
                        state_reg    <= OCC_FULL;
                        in_ready_reg <= 1'b0;
                    end else if (pop && !push && (count_reg == CW'(1))) begin
                        state_reg     <= OCC_EMPTY;
                        out_valid_reg <= 1'b0;
                    end
                end
                OCC_FULL: begin
                    if (pop) begin
                        state_reg    <= OCC_PARTIAL;
                        in_ready_reg <= 1'b1;
                    end
                end
                default: begin
                    state_reg     <= OCC_EMPTY;
                    in_ready_reg  <= 1'b1;
                    out_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    // Head is masked while empty so stale storage never reaches the port.
    assign q_if.in_ready  = in_ready_reg;
    assign q_if.out_valid = out_valid_reg;
    assign q_if.out_sel   = out_valid_reg ? head_entry.sel : ALU_ADD;
    assign q_if.out_res   = out_valid_reg ? head_entry.res : '0;
    assign q_if.out_zero  = out_valid_reg && (head_entry.res == '0);

    assign count   = count_reg;
    assign retired = retired_reg;

endmodule

// File: tb/tb_alu_result_queue.sv
// Self-checking bench for alu_result_queue against a queue-based model.
module tb_alu_result_queue;
    import pd_alu_pkg::*;

    localparam int DEPTH = 4;
    localparam int DW    = 32;
    localparam int CNT_W = 16;

    typedef struct packed {
        logic [1:0]    sel;
        logic [DW-1:0] res;
    } ent_t;

    logic                   clock;
    logic                   reset;
    logic                   flush;
    logic [$clog2(DEPTH):0] count;
    logic [CNT_W-1:0]       retired;

    alu_result_queue_if #(.DWIDTH(DW)) bus ();

    alu_result_queue #(
        .DEPTH  (DEPTH),
        .DWIDTH (DW),
        .CNT_W  (CNT_W)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .q_if    (bus.slave),
        .flush   (flush),
        .count   (count),
        .retired (retired)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int         checks = 0;
    int         errors = 0;
    ent_t       q[$];
    logic [CNT_W-1:0] m_retired = '0;
    bit         last_push;
    bit         last_pop;

    // One clock of stimulus; the model advances on the same edge.
    task automatic drive(input bit v, input logic [1:0] s, input logic [DW-1:0] r,
                         input bit rdy, input bit fl, input bit rst);
        ent_t e;
        reset         = rst;
        flush         = fl;
        bus.in_valid  = v;
        bus.in_sel    = alu_sel_t'(s);
        bus.in_res    = r;
        bus.out_ready = rdy;
        last_push = !rst && !fl && v && (q.size() < DEPTH);
        last_pop  = !rst && !fl && rdy && (q.size() > 0);
        e.sel = s;
        e.res = r;
        @(posedge clock);
        if (rst) begin
            q.delete();
            m_retired = '0;
        end else if (fl) begin
            q.delete();
        end else begin
            if (last_pop) begin
                void'(q.pop_front());
                m_retired = m_retired + 1'b1;
            end
            if (last_push) q.push_back(e);
        end
        #1;
    endtask

    // Occupancy invariants observed on the DUT itself.
    always @(negedge clock) begin
        if (!reset) begin
            checks++;
            if (count > DEPTH) begin
                errors++;
                $display("FAIL inv_count count=%0d max=%0d", count, DEPTH);
            end
            checks++;
            if ((count == 0) && bus.out_valid) begin
                errors++;
                $display("FAIL inv_pop_empty out_valid=%0b exp=0", bus.out_valid);
            end
            checks++;
            if ((count == DEPTH) && bus.in_ready) begin
                errors++;
                $display("FAIL inv_push_full in_ready=%0b exp=0", bus.in_ready);
            end
        end
    end

    task automatic test_reset();
        drive(0, 2'b00, '0, 0, 0, 1);
        drive(0, 2'b00, '0, 0, 0, 1);
        checks++;
        if (count !== 0) begin errors++; $display("FAIL rst_count got=%0d exp=0", count); end
        checks++;
        if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got=%0b exp=1", bus.in_ready); end
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got=%0b exp=0", bus.out_valid); end
        checks++;
        if (retired !== 0) begin errors++; $display("FAIL rst_retired got=%0d exp=0", retired); end
        checks++;
        if (bus.out_res !== 0 || bus.out_sel !== 2'b00 || bus.out_zero !== 1'b0) begin
            errors++;
            $display("FAIL rst_head res=%0h sel=%0d zero=%0b exp=0/0/0", bus.out_res, bus.out_sel, bus.out_zero);
        end
        $display("test_reset done");
    endtask

    task automatic test_basic();
        drive(1, 2'b00, 32'd30, 1, 0, 0);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_res !== 32'd30) begin
            errors++; $display("FAIL basic_first valid=%0b res=%0d exp=1/30", bus.out_valid, bus.out_res);
        end
        drive(1, 2'b01, 32'd10, 1, 0, 0);
        checks++;
        if (bus.out_res !== 32'd10 || bus.out_sel !== 2'b01 || count !== 1) begin
            errors++; $display("FAIL basic_second res=%0d sel=%0d count=%0d exp=10/1/1", bus.out_res, bus.out_sel, count);
        end
        drive(0, 2'b00, '0, 1, 0, 0);
        checks++;
        if (retired !== 16'd2 || count !== 0) begin
            errors++; $display("FAIL basic_end retired=%0d count=%0d exp=2/0", retired, count);
        end
        $display("test_basic done");
    endtask

    task automatic test_zero_flag();
        logic [DW-1:0] wrapped;
        wrapped = 32'hFFFF_FFFF;
        wrapped = wrapped + 1;
        drive(1, 2'b00, wrapped, 0, 0, 0);
        checks++;
        if (bus.out_zero !== 1'b1) begin errors++; $display("FAIL zero_first got=%0b exp=1", bus.out_zero); end
        drive(1, 2'b01, 32'hFFFF_FFFF, 0, 0, 0);
        checks++;
        if (bus.out_zero !== 1'b1 || count !== 2) begin
            errors++; $display("FAIL zero_hold zero=%0b count=%0d exp=1/2", bus.out_zero, count);
        end
        drive(0, 2'b00, '0, 1, 0, 0);
        checks++;
        if (bus.out_zero !== 1'b0 || bus.out_res !== 32'hFFFF_FFFF || bus.out_sel !== 2'b01) begin
            errors++; $display("FAIL zero_second zero=%0b res=%0h sel=%0d exp=0/ffffffff/1", bus.out_zero, bus.out_res, bus.out_sel);
        end
        drive(0, 2'b00, '0, 1, 0, 0);
        $display("test_zero_flag done");
    endtask

    task automatic test_full();
        logic [DW-1:0] vals [5];
        bit held;
        vals[0] = 32'hAAAA_AAAA; vals[1] = 32'h0; vals[2] = 32'hFFFF_FFFF;
        vals[3] = 32'h1; vals[4] = 32'h2;
        for (int i = 0; i < 4; i++) begin
            drive(1, 2'b10, vals[i], 0, 0, 0);
            checks++;
            if (bus.in_ready !== (i < 3)) begin
                errors++; $display("FAIL full_in_ready push=%0d got=%0b exp=%0b", i, bus.in_ready, i < 3);
            end
        end
        drive(1, 2'b11, vals[4], 0, 0, 0);
        checks++;
        if (count !== 4 || bus.out_res !== 32'hAAAA_AAAA) begin
            errors++; $display("FAIL full_hold count=%0d res=%0h exp=4/aaaaaaaa", count, bus.out_res);
        end
        held = 1;
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_res !== vals[k]) begin
                errors++; $display("FAIL full_drain k=%0d valid=%0b res=%0h exp=1/%0h", k, bus.out_valid, bus.out_res, vals[k]);
            end
            drive(held, 2'b11, vals[4], 1, 0, 0);
            if (last_push) held = 0;
        end
        checks++;
        if (count !== 0 || held) begin
            errors++; $display("FAIL full_end count=%0d held=%0b exp=0/0", count, held);
        end
        $display("test_full done");
    endtask

    task automatic test_back_to_back();
        ent_t exp_head;
        drive(1, 2'($urandom), $urandom, 0, 0, 0);
        drive(1, 2'($urandom), $urandom, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            exp_head = q[0];
            checks++;
            if (bus.out_res !== exp_head.res || bus.out_sel !== exp_head.sel) begin
                errors++; $display("FAIL b2b_order i=%0d res=%0h sel=%0d exp=%0h/%0d", i, bus.out_res, bus.out_sel, exp_head.res, exp_head.sel);
            end
            drive(1, 2'($urandom), $urandom, 1, 0, 0);
            checks++;
            if (count !== 2) begin errors++; $display("FAIL b2b_count i=%0d got=%0d exp=2", i, count); end
        end
        drive(0, 2'b00, '0, 1, 0, 0);
        drive(0, 2'b00, '0, 1, 0, 0);
        $display("test_back_to_back done");
    endtask

    task automatic test_flush();
        logic [CNT_W-1:0] r0;
        for (int i = 0; i < 3; i++) drive(1, 2'($urandom), $urandom, 0, 0, 0);
        r0 = m_retired;
        drive(1, 2'b01, 32'h1234, 1, 1, 0);
        checks++;
        if (count !== 0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL flush_state count=%0d valid=%0b ready=%0b exp=0/0/1", count, bus.out_valid, bus.in_ready);
        end
        checks++;
        if (retired !== r0) begin errors++; $display("FAIL flush_retired got=%0d exp=%0d", retired, r0); end
        drive(1, 2'b10, 32'h5A5A, 0, 0, 0);
        checks++;
        if (bus.out_res !== 32'h5A5A || count !== 1) begin
            errors++; $display("FAIL flush_after res=%0h count=%0d exp=5a5a/1", bus.out_res, count);
        end
        drive(0, 2'b00, '0, 1, 0, 0);
        $display("test_flush done");
    endtask

    task automatic test_reset_mid();
        drive(0, 2'b00, '0, 0, 0, 1);
        for (int i = 0; i < 7; i++) begin
            drive(1, 2'($urandom), $urandom, 0, 0, 0);
            drive(0, 2'b00, '0, 1, 0, 0);
        end
        checks++;
        if (retired !== 16'd7) begin errors++; $display("FAIL mid_retired7 got=%0d exp=7", retired); end
        for (int i = 0; i < 3; i++) drive(1, 2'($urandom), $urandom, 0, 0, 0);
        drive(1, 2'b00, 32'h77, 1, 1, 1);
        checks++;
        if (count !== 0 || retired !== 0 || bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL mid_reset count=%0d retired=%0d ready=%0b valid=%0b exp=0/0/1/0", count, retired, bus.in_ready, bus.out_valid);
        end
        $display("test_reset_mid done");
    endtask

    task automatic test_random();
        ent_t h;
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, 2'($urandom),
                  ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom,
                  $urandom_range(0, 2) != 0, $urandom_range(0, 31) == 0, 0);
            checks++;
            if (count !== q.size() || retired !== m_retired) begin
                errors++; $display("FAIL rand_state i=%0d count=%0d retired=%0d exp=%0d/%0d", i, count, retired, q.size(), m_retired);
            end
            checks++;
            if (bus.in_ready !== (q.size() != DEPTH) || bus.out_valid !== (q.size() != 0)) begin
                errors++; $display("FAIL rand_hs i=%0d ready=%0b valid=%0b size=%0d", i, bus.in_ready, bus.out_valid, q.size());
            end
            if (q.size() != 0) h = q[0];
            else h = '0;
            checks++;
            if (bus.out_res !== h.res || bus.out_sel !== h.sel || bus.out_zero !== ((q.size() != 0) && (h.res == 0))) begin
                errors++; $display("FAIL rand_head i=%0d res=%0h sel=%0d zero=%0b exp=%0h/%0d", i, bus.out_res, bus.out_sel, bus.out_zero, h.res, h.sel);
            end
        end
        $display("test_random done");
    endtask

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_sel    = ALU_ADD;
        bus.in_res    = '0;
        bus.out_ready = 1'b0;
        test_reset();
        test_basic();
        test_zero_flag();
        test_full();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
